// File: rtl/i2c_config_sequencer.sv
// Walks a register-init table and launches one 16-bit word per I2C write-engine transfer, retrying NACKed words.
// Latency: start -> busy 1 cycle; per entry 4 cycles + engine transfer time; each wait state bounded by TIMEOUT.
// Backpressure: the engine is held parked (i2c_enable=1) except in LAUNCH/WAIT_LO; a new word waits for i2c_end.
//
// Ports: clk/reset (async active-low); start (level, sampled in IDLE); lut_index/lut_data to the external table;
// i2c_reg_data/i2c_sl_addr/i2c_byte_num/i2c_enable to the engine, i2c_end/i2c_ack from it;
// busy/done/error/err_index status to the system controller.
module i2c_config_sequencer #(
    parameter int          LUT_SIZE   = 24,
    parameter int          IDX_W      = 5,
    parameter logic [7:0]  SLAVE_ADDR = 8'hBA,
    parameter int          BYTE_NUM   = 2,
    parameter int          MAX_RETRY  = 3,
    parameter int          TIMEOUT    = 1023,
    parameter int          AUTO_START = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [IDX_W-1:0] lut_index,
    input  logic [15:0]      lut_data,
    output logic [15:0]      i2c_reg_data,
    output logic [7:0]       i2c_sl_addr,
    output logic [7:0]       i2c_byte_num,
    output logic             i2c_enable,
    input  logic             i2c_end,
    input  logic             i2c_ack,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] err_index
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LUT_SIZE - 1);
    localparam logic [TW-1:0]    TIMER_MAX = TW'(TIMEOUT);
    localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE, LOAD, LAUNCH, WAIT_LO, WAIT_HI, CHECK
    } state_t;

    state_t          state, next_state;
    logic [TW-1:0]   timer;
    logic [RW-1:0]   retry;
    logic            auto_pend;  // one-shot request to run the table after reset release
    logic            timed_out;  // current attempt ended by the watchdog; treated as a NACK
    logic            go, tmo, nack, last_entry, can_retry;

    assign i2c_sl_addr  = SLAVE_ADDR;
    assign i2c_byte_num = 8'(BYTE_NUM);

    always_comb begin
        go         = start | auto_pend;
        tmo        = (timer == TIMER_MAX);
        nack       = i2c_ack | timed_out;
        last_entry = (lut_index == LAST_IDX);
        can_retry  = (retry < RETRY_MAX);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (go) next_state = LOAD;
            LOAD:    next_state = LAUNCH;
            LAUNCH:  next_state = WAIT_LO;
            WAIT_LO: begin
                if (!i2c_end)  next_state = WAIT_HI;
                else if (tmo)  next_state = CHECK;
            end
            WAIT_HI: if (i2c_end || tmo) next_state = CHECK;
            CHECK: begin
                if (nack) next_state = can_retry ? LOAD : IDLE;
                else      next_state = last_entry ? IDLE : LOAD;
            end
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i2c_enable   <= 1'b1;
            i2c_reg_data <= '0;
            lut_index    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_index    <= '0;
            retry        <= '0;
            timer        <= '0;
            timed_out    <= 1'b0;
            auto_pend    <= (AUTO_START != 0);
        end else begin
            case (state)
                IDLE: begin
                    auto_pend <= 1'b0;
                    if (go) begin
                        lut_index <= '0;
                        retry     <= '0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    i2c_reg_data <= lut_data;
                    timed_out    <= 1'b0;
                end
                LAUNCH: begin
                    i2c_enable <= 1'b0;
                    timer      <= '0;
                end
                WAIT_LO: begin
                    // Re-park as soon as the engine has taken the launch so it
                    // cannot start a second transfer when it returns to idle.
                    if (!i2c_end) begin
                        i2c_enable <= 1'b1;
                        timer      <= '0;
                    end else if (tmo) begin
                        i2c_enable <= 1'b1;
                        timed_out  <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WAIT_HI: begin
                    if (!i2c_end) begin
                        if (tmo) timed_out <= 1'b1;
                        else     timer     <= timer + TW'(1);
                    end
                end
                CHECK: begin
                    if (nack) begin
                        if (can_retry) begin
                            retry <= retry + RW'(1);
                        end else begin
                            error     <= 1'b1;
                            err_index <= lut_index;
                            busy      <= 1'b0;
                        end
                    end else if (last_entry) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        lut_index <= lut_index + IDX_W'(1);
                        retry     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Directed bench for i2c_config_sequencer with a 4-entry table and a behavioural write-engine responder.
// Latency: n/a (testbench).
// Backpressure: the engine model holds i2c_end low for a fixed transfer time, or forever in hang mode.
module tb_i2c_config_sequencer;

    localparam int LUT_SIZE = 4;
    localparam int IDX_W    = 2;
    localparam int TIMEOUT  = 63;
    localparam int XFER     = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [IDX_W-1:0] lut_index;
    logic [15:0]      lut_data;
    logic [15:0]      i2c_reg_data;
    logic [7:0]       i2c_sl_addr;
    logic [7:0]       i2c_byte_num;
    logic             i2c_enable;
    logic             i2c_end = 1'b1;
    logic             i2c_ack = 1'b0;
    logic             busy, done, error;
    logic [IDX_W-1:0] err_index;

    logic [15:0] tbl [LUT_SIZE];
    assign lut_data = tbl[lut_index];

    int checks = 0;
    int errors = 0;

    // Engine model controls, written only by the stimulus block
    int   nack_mode = 0;  // 0 always ack, 1 entry 2 NACKs first attempt, 2 entry 1 always NACKs
    logic hang = 1'b0;    // engine ignores launches and never drops i2c_end

    // Observations recorded by the engine model, cleared at each busy rise
    logic [15:0]      log_q [$];
    logic [IDX_W-1:0] idx_q [$];
    logic [15:0]      fin_q [$];
    int               attempts [LUT_SIZE];
    int               last_low = 0;

    i2c_config_sequencer #(
        .LUT_SIZE(LUT_SIZE), .IDX_W(IDX_W), .SLAVE_ADDR(8'hBA), .BYTE_NUM(2),
        .MAX_RETRY(3), .TIMEOUT(TIMEOUT), .AUTO_START(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .lut_index(lut_index), .lut_data(lut_data),
        .i2c_reg_data(i2c_reg_data), .i2c_sl_addr(i2c_sl_addr), .i2c_byte_num(i2c_byte_num),
        .i2c_enable(i2c_enable), .i2c_end(i2c_end), .i2c_ack(i2c_ack),
        .busy(busy), .done(done), .error(error), .err_index(err_index)
    );

    always #5 clk = ~clk;

    // Write-engine responder, evaluated on the falling edge
    logic eng_busy = 1'b0, prev_en = 1'b1, prev_busy = 1'b0, pend_nack = 1'b0;
    int   cnt = 0, low_run = 0;
    always @(negedge clk) begin
        if (!reset) begin
            i2c_end   = 1'b1;
            i2c_ack   = 1'b0;
            eng_busy  = 1'b0;
            cnt       = 0;
            prev_en   = 1'b1;
            prev_busy = 1'b0;
            low_run   = 0;
        end else begin
            if (busy && !prev_busy) begin
                log_q.delete();
                idx_q.delete();
                fin_q.delete();
                for (int i = 0; i < LUT_SIZE; i++) attempts[i] = 0;
            end
            prev_busy = busy;
            if (!i2c_enable) low_run++;
            else if (low_run != 0) begin
                last_low = low_run;
                low_run  = 0;
            end
            if (eng_busy) begin
                if (cnt == 0) begin
                    i2c_end  = 1'b1;
                    i2c_ack  = pend_nack;
                    eng_busy = 1'b0;
                    fin_q.push_back(i2c_reg_data);
                end else begin
                    cnt--;
                end
            end else if (prev_en && !i2c_enable && i2c_end) begin
                log_q.push_back(i2c_reg_data);
                idx_q.push_back(lut_index);
                attempts[lut_index]++;
                pend_nack = (nack_mode == 1 && lut_index == 2 && attempts[2] == 1) ||
                            (nack_mode == 2 && lut_index == 1);
                if (!hang) begin
                    i2c_end  = 1'b0;
                    i2c_ack  = 1'b0;
                    eng_busy = 1'b1;
                    cnt      = XFER;
                end
            end
            prev_en = i2c_enable;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (busy !== 1'b0 && n < max) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        chk({tag, "_busy_before"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_busy_after"}, 32'(busy), 32'd1);
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
        chk({tag, "_error_clr"}, 32'(error), 32'd0);
        start = 1'b0;
    endtask

    // Launches must carry the table word of their index, unchanged at completion
    task automatic chk_log(input string tag, input logic [15:0] exp_words [$]);
        chk({tag, "_n_launch"}, 32'(log_q.size()), 32'(exp_words.size()));
        for (int i = 0; i < log_q.size() && i < exp_words.size(); i++) begin
            chk($sformatf("%s_word%0d", tag, i), 32'(log_q[i]), 32'(exp_words[i]));
            chk($sformatf("%s_idx_match%0d", tag, i), 32'(log_q[i]), 32'(tbl[idx_q[i]]));
        end
        for (int i = 0; i < fin_q.size() && i < log_q.size(); i++)
            chk($sformatf("%s_stable%0d", tag, i), 32'(fin_q[i]), 32'(log_q[i]));
    endtask

    initial begin
        logic [15:0] exp_q [$];
        int n;
        tbl[0] = 16'h1234; tbl[1] = 16'hFFFF; tbl[2] = 16'hABCD; tbl[3] = 16'h0001;

        // Reset values
        #12;
        chk("rst_enable", 32'(i2c_enable), 32'd1);
        chk("rst_reg_data", 32'(i2c_reg_data), 32'd0);
        chk("rst_index", 32'(lut_index), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_err_index", 32'(err_index), 32'd0);
        chk("sl_addr", 32'(i2c_sl_addr), 32'h00BA);
        chk("byte_num", 32'(i2c_byte_num), 32'd2);

        // Clean pass started automatically after reset release
        @(negedge clk); reset = 1'b1;
        wait_busy("auto");
        wait_idle("auto", 500);
        chk("auto_done", 32'(done), 32'd1);
        chk("auto_error", 32'(error), 32'd0);
        chk("auto_enable", 32'(i2c_enable), 32'd1);
        exp_q = '{16'h1234, 16'hFFFF, 16'hABCD, 16'h0001};
        chk_log("auto", exp_q);

        // Restart from done, entry 2 NACKs its first attempt only
        nack_mode = 1;
        pulse_start("nack1");
        wait_idle("nack1", 500);
        chk("nack1_done", 32'(done), 32'd1);
        chk("nack1_error", 32'(error), 32'd0);
        exp_q = '{16'h1234, 16'hFFFF, 16'hABCD, 16'hABCD, 16'h0001};
        chk_log("nack1", exp_q);

        // Entry 1 always NACKs: four attempts then abort
        nack_mode = 2;
        pulse_start("exh");
        wait_idle("exh", 800);
        chk("exh_error", 32'(error), 32'd1);
        chk("exh_done", 32'(done), 32'd0);
        chk("exh_err_index", 32'(err_index), 32'd1);
        exp_q = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        chk_log("exh", exp_q);
        n = 0;
        foreach (idx_q[i]) if (idx_q[i] == 2) n++;
        chk("exh_no_entry2", 32'(n), 32'd0);

        // Engine never responds: watchdog ends each attempt
        nack_mode = 0;
        hang = 1'b1;
        pulse_start("tmo");
        wait_idle("tmo", 1000);
        chk("tmo_error", 32'(error), 32'd1);
        chk("tmo_done", 32'(done), 32'd0);
        chk("tmo_err_index", 32'(err_index), 32'd0);
        chk("tmo_enable", 32'(i2c_enable), 32'd1);
        exp_q = '{16'h1234, 16'h1234, 16'h1234, 16'h1234};
        chk_log("tmo", exp_q);
        chk("tmo_low_len", 32'(last_low >= TIMEOUT && last_low <= TIMEOUT + 1), 32'd1);
        hang = 1'b0;

        // Reset during WAIT_HI of entry 2, then automatic replay
        pulse_start("rmid");
        n = 0;
        while (!(lut_index == 2 && !i2c_end && i2c_enable) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("rmid_reach_wait_hi", 32'(lut_index == 2 && !i2c_end), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rmid_enable", 32'(i2c_enable), 32'd1);
        chk("rmid_busy", 32'(busy), 32'd0);
        chk("rmid_done", 32'(done), 32'd0);
        chk("rmid_error", 32'(error), 32'd0);
        chk("rmid_index", 32'(lut_index), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        wait_busy("rmid");
        chk("rmid_index_restart", 32'(lut_index), 32'd0);
        wait_idle("rmid", 500);
        chk("rmid_done_after", 32'(done), 32'd1);
        exp_q = '{16'h1234, 16'hFFFF, 16'hABCD, 16'h0001};
        chk_log("rmid", exp_q);

        // Plain restart after done
        pulse_start("rst2");
        wait_idle("rst2", 500);
        chk("rst2_done", 32'(done), 32'd1);
        chk_log("rst2", exp_q);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
